// File: rtl/btn_color_sel.sv
// Pushbutton front end: 2-flop synchronizer, per-bit debounce, press detect and one-hot colour select.
// Optional build macro BTN_COLOR_SEL_TOGGLE_EN: re-pressing the selected colour turns it off.
module btn_color_sel #(
    parameter int unsigned NB_BTN  = 3,
    parameter int unsigned CNT_MAX = 1000000,
    parameter int unsigned NB_CNT  = 20
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_btn,
    output logic [NB_BTN-1:0] o_press,
    output logic [NB_BTN-1:0] o_sel
);

    localparam logic [NB_CNT-1:0] CntLast = NB_CNT'(CNT_MAX - 1);

    logic [NB_BTN-1:0] sync1;
    logic [NB_BTN-1:0] sync2;
    logic [NB_BTN-1:0] btn_prev;
    logic [NB_BTN-1:0] rise;
    logic [NB_BTN-1:0] win;
    logic [NB_BTN-1:0] sel_next;
    logic [NB_CNT-1:0] cnt [NB_BTN];

    // Debounce: the debounced level flips only after CNT_MAX consecutive cycles of disagreement.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            sync1 <= '0;
            sync2 <= '0;
            o_btn <= '0;
            for (int i = 0; i < NB_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
            for (int i = 0; i < NB_BTN; i++) begin
                if (sync2[i] == o_btn[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CntLast) begin
                    o_btn[i] <= ~o_btn[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + NB_CNT'(1);
                end
            end
        end
    end

    assign rise = o_btn & ~btn_prev;

    // Ascending scan: the highest-index pressed bit is the last one written.
    always_comb begin
        win = '0;
        for (int i = 0; i < NB_BTN; i++) begin
            if (rise[i]) begin
                win    = '0;
                win[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_next = o_sel;
        if (rise != '0) begin
`ifdef BTN_COLOR_SEL_TOGGLE_EN
            if (win == o_sel) begin
                sel_next = '0;
            end else begin
                sel_next = win;
            end
`else
            sel_next = win;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            btn_prev <= '0;
            o_press  <= '0;
            o_sel    <= '0;
        end else begin
            btn_prev <= o_btn;
            o_press  <= rise;
            o_sel    <= sel_next;
        end
    end

endmodule

// File: tb/tb_btn_color_sel.sv
// Directed bench for btn_color_sel with CNT_MAX=16; a cycle-level behavioural model is checked
// every cycle, plus literal expectations at the key latency points.
module tb_btn_color_sel;

    localparam int unsigned NB     = 3;
    localparam int unsigned CNTMAX = 16;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [NB-1:0] i_btn = '0;
    logic [NB-1:0] o_btn;
    logic [NB-1:0] o_press;
    logic [NB-1:0] o_sel;

    int n_checks = 0;
    int n_fails  = 0;
    int n_pulses = 0;
    bit check_en = 1'b0;

    btn_color_sel #(
        .NB_BTN (NB),
        .CNT_MAX(CNTMAX),
        .NB_CNT (5)
    ) dut (
        .clk    (clk),
        .i_reset(i_reset),
        .i_btn  (i_btn),
        .o_btn  (o_btn),
        .o_press(o_press),
        .o_sel  (o_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Model: tracks sampled history and how long each synchronized bit has disagreed.
    logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_rose = '0, m_press = '0, m_sel = '0;
    int            m_run [NB];

    always @(posedge clk) begin
        if (i_reset) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_rose = '0; m_press = '0; m_sel = '0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
        end else begin
            m_press = m_rose;
            if (m_press != '0) begin
                logic [NB-1:0] w;
                w = '0;
                if (m_press[2]) w = 3'b100;
                else if (m_press[1]) w = 3'b010;
                else w = 3'b001;
`ifdef BTN_COLOR_SEL_TOGGLE_EN
                m_sel = (m_sel == w) ? 3'b000 : w;
`else
                m_sel = w;
`endif
            end
            m_rose = '0;
            for (int i = 0; i < NB; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == int'(CNTMAX)) begin
                        m_db[i]  = ~m_db[i];
                        m_run[i] = 0;
                        if (m_db[i]) m_rose[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = i_btn;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_o_btn", o_btn, m_db);
            check("model_o_press", o_press, m_press);
            check("model_o_sel", o_sel, m_sel);
            if (o_press != '0) n_pulses++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle_press(input logic [NB-1:0] b);
        i_btn = b;
        tick(25);
    endtask

    initial begin
        int p0;
        // 1: reset, then idle
        @(negedge clk);
        i_reset = 1'b1;
        tick(3);
        check_en = 1'b1;
        check("rst_o_btn", o_btn, 3'b000);
        check("rst_o_press", o_press, 3'b000);
        check("rst_o_sel", o_sel, 3'b000);
        i_reset = 1'b0;
        tick(100);
        check("idle_o_sel", o_sel, 3'b000);

        // 2: red press latency
        i_btn = 3'b100;
        tick(17);
        check("lat_btn_before", o_btn, 3'b000);
        tick(1);
        check("lat_btn_rise", o_btn, 3'b100);
        check("lat_press_before", o_press, 3'b000);
        tick(1);
        check("lat_press", o_press, 3'b100);
        check("lat_sel", o_sel, 3'b100);
        tick(1);
        check("lat_press_one_cycle", o_press, 3'b000);
        settle_press(3'b000);

        // 3: bounce on green, shorter than CNT_MAX
        p0 = n_pulses;
        for (int r = 0; r < 5; r++) begin
            i_btn = 3'b010;
            tick(10);
            i_btn = 3'b000;
            tick(10);
        end
        tick(20);
        n_checks++;
        if (n_pulses != p0) begin
            n_fails++;
            $display("FAIL bounce_pulses: got %0d, expected %0d", n_pulses - p0, 0);
        end
        check("bounce_sel", o_sel, 3'b100);
        check("bounce_btn", o_btn, 3'b000);

        // 4: simultaneous green+blue
        p0 = n_pulses;
        i_btn = 3'b011;
        tick(18);
        check("simul_press_pre", o_press, 3'b000);
        tick(1);
        check("simul_press", o_press, 3'b011);
        check("simul_sel", o_sel, 3'b010);
        tick(24);
        settle_press(3'b000);
        n_checks++;
        if (n_pulses - p0 != 1) begin
            n_fails++;
            $display("FAIL simul_pulse_count: got %0d, expected %0d", n_pulses - p0, 1);
        end
        check("release_sel", o_sel, 3'b010);
        check("release_btn", o_btn, 3'b000);

        // 5: blue, release, re-press blue
        settle_press(3'b001);
        check("blue_sel", o_sel, 3'b001);
        settle_press(3'b000);
        settle_press(3'b001);
`ifdef BTN_COLOR_SEL_TOGGLE_EN
        check("repress_sel", o_sel, 3'b000);
`else
        check("repress_sel", o_sel, 3'b001);
`endif
        settle_press(3'b000);

        // 6: reset mid-count with red held
        i_btn = 3'b100;
        tick(12);
        i_reset = 1'b1;
        tick(1);
        check("midrst_btn", o_btn, 3'b000);
        check("midrst_press", o_press, 3'b000);
        check("midrst_sel", o_sel, 3'b000);
        i_reset = 1'b0;
        tick(18);
        check("post_rst_btn", o_btn, 3'b100);
        check("post_rst_press_pre", o_press, 3'b000);
        tick(1);
        check("post_rst_press", o_press, 3'b100);
        check("post_rst_sel", o_sel, 3'b100);
        tick(1);
        check("post_rst_press_end", o_press, 3'b000);
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
